product_accumulator: RTL

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 109 ++++++++++
 1 files changed

// File: rtl/product_accumulator.sv
// Burst accumulator for 16x16 products with valid/ready in and out.
// Define PRODUCT_ACC_SAT_EN to clamp on overflow instead of wrapping.
module product_accumulator #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_product,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {ACC, HOLD} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             oovf_q, oovf_d;

  logic [ACC_W:0]   add;
  logic [ACC_W-1:0] acc_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             ovf_nx;

  assign add = {1'b0, acc_q}
             + {{(ACC_W - 31){1'b0}}, in_product};
  assign ovf_nx = ovf_q | add[ACC_W];
  assign cnt_nx = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef PRODUCT_ACC_SAT_EN
  // once saturated the accumulator stays pinned for the burst
  assign acc_nx = ovf_nx ? '1 : add[ACC_W-1:0];
`else
  assign acc_nx = add[ACC_W-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    sum_d     = sum_q;
    count_d   = count_q;
    oovf_d    = oovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = acc_nx;
          cnt_d = cnt_nx;
          ovf_d = ovf_nx;
          if (in_last) begin
            sum_d   = acc_nx;
            count_d = cnt_nx;
            oovf_d  = ovf_nx;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      oovf_q  <= oovf_d;
    end
  end

  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign out_ovf   = oovf_q;

endmodule
